// File: rtl/granth_crc_engine.sv
// Bit-serial CRC datapath: latches a CRC configuration, folds message bytes in one bit per clock,
// and streams the finalised (reflected / XORed) result out one byte per cycle, LSB byte first.
module granth_crc_engine #(
  parameter int BITWIDTH = 64,
  parameter int CNTW     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BITWIDTH-1:0] cfg_poly,
  input  logic [BITWIDTH-1:0] cfg_init,
  input  logic [BITWIDTH-1:0] cfg_xor,
  input  logic [5:0]          cfg_width,
  input  logic                cfg_reflect_in,
  input  logic                cfg_reflect_out,
  input  logic                init_req,
  input  logic                msg_valid,
  input  logic [7:0]          msg_byte,
  output logic                msg_ready,
  input  logic                final_req,
  output logic                out_valid,
  output logic [7:0]          out_byte,
  output logic                busy
);

  localparam int WBITS = $clog2(BITWIDTH + 1);
  localparam int IW    = $clog2(BITWIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, OUTPUT} state_t;

  state_t              state_reg;
  logic [BITWIDTH-1:0] acc_reg, poly_reg, init_reg, xor_reg, res_reg;
  logic [5:0]          width_reg;
  logic                rin_reg, rout_reg;
  logic [7:0]          sh_reg;
  logic [CNTW-1:0]     cnt_reg;
  logic [WBITS-1:0]    idx_reg;

  // Effective widths: an encoded width of 0 means the full bus width.
  logic [WBITS-1:0]    w_lat, w_cfg, rev_sh, n_bytes;
  logic [IW-1:0]       top_idx;
  logic [BITWIDTH-1:0] mask_lat, mask_cfg, acc_rev_full, acc_rev;
  logic [BITWIDTH-1:0] acc_shift_next, res_next, res_shift;
  logic [7:0]          msg_rev;
  logic                fb;

  assign w_lat   = (width_reg == 6'd0) ? WBITS'(BITWIDTH) : WBITS'(width_reg);
  assign w_cfg   = (cfg_width == 6'd0) ? WBITS'(BITWIDTH) : WBITS'(cfg_width);
  assign rev_sh  = WBITS'(BITWIDTH) - w_lat;
  assign n_bytes = (w_lat + WBITS'(7)) >> 3;
  assign top_idx = IW'(w_lat - WBITS'(1));

  genvar gi;
  generate
    for (gi = 0; gi < BITWIDTH; gi++) begin : g_bits
      assign mask_lat[gi]     = (WBITS'(gi) < w_lat);
      assign mask_cfg[gi]     = (WBITS'(gi) < w_cfg);
      assign acc_rev_full[gi] = acc_reg[BITWIDTH-1-gi];
    end
    for (gi = 0; gi < 8; gi++) begin : g_byte_rev
      assign msg_rev[gi] = msg_byte[7-gi];
    end
  endgenerate

  // Reversing the whole bus then shifting down by (BITWIDTH-W) reverses bits [W-1:0] only.
  assign acc_rev        = acc_rev_full >> rev_sh;
  assign fb             = acc_reg[top_idx] ^ sh_reg[7];
  assign acc_shift_next = ((acc_reg << 1) ^ (fb ? poly_reg : '0)) & mask_lat;
  assign res_next       = ((rout_reg ? acc_rev : acc_reg) ^ xor_reg) & mask_lat;
  assign res_shift      = res_reg >> {idx_reg, 3'b000};

  assign msg_ready = (state_reg == IDLE) & ~init_req & ~final_req;
  assign busy      = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      poly_reg  <= '0;
      init_reg  <= '0;
      xor_reg   <= '0;
      res_reg   <= '0;
      width_reg <= 6'd32;
      rin_reg   <= 1'b0;
      rout_reg  <= 1'b0;
      sh_reg    <= '0;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      out_valid <= 1'b0;
      out_byte  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (init_req) begin
            poly_reg  <= cfg_poly;
            init_reg  <= cfg_init;
            xor_reg   <= cfg_xor;
            width_reg <= cfg_width;
            rin_reg   <= cfg_reflect_in;
            rout_reg  <= cfg_reflect_out;
            acc_reg   <= cfg_init & mask_cfg;
          end else if (final_req) begin
            res_reg   <= res_next;
            out_valid <= 1'b1;
            out_byte  <= res_next[7:0];
            idx_reg   <= WBITS'(1);
            state_reg <= OUTPUT;
          end else if (msg_valid) begin
            sh_reg    <= rin_reg ? msg_rev : msg_byte;
            cnt_reg   <= '0;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          acc_reg <= acc_shift_next;
          sh_reg  <= {sh_reg[6:0], 1'b0};
          cnt_reg <= cnt_reg + 1'b1;
          if (&cnt_reg) state_reg <= IDLE;
        end
        OUTPUT: begin
          if (idx_reg == n_bytes) begin
            out_valid <= 1'b0;
            out_byte  <= '0;
            state_reg <= IDLE;
          end else begin
            out_byte <= res_shift[7:0];
            idx_reg  <= idx_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_granth_crc_engine.sv
// Directed bench for granth_crc_engine: standard CRC catalogue results over "123456789",
// handshake timing, request priority and asynchronous abort.
module tb_granth_crc_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] cfg_poly = '0, cfg_init = '0, cfg_xor = '0;
  logic [5:0]  cfg_width = '0;
  logic        cfg_reflect_in = 1'b0, cfg_reflect_out = 1'b0;
  logic        init_req = 1'b0, msg_valid = 1'b0, final_req = 1'b0;
  logic [7:0]  msg_byte = '0;
  logic        msg_ready, out_valid, busy;
  logic [7:0]  out_byte;

  int vectors = 0;
  int miscompares = 0;

  granth_crc_engine #(.BITWIDTH(64), .CNTW(3)) dut (
    .clk(clk), .rst(rst),
    .cfg_poly(cfg_poly), .cfg_init(cfg_init), .cfg_xor(cfg_xor), .cfg_width(cfg_width),
    .cfg_reflect_in(cfg_reflect_in), .cfg_reflect_out(cfg_reflect_out),
    .init_req(init_req), .msg_valid(msg_valid), .msg_byte(msg_byte), .msg_ready(msg_ready),
    .final_req(final_req), .out_valid(out_valid), .out_byte(out_byte), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic do_init(input logic [63:0] poly, input logic [63:0] init, input logic [63:0] xr,
                         input logic [5:0] w, input logic rin, input logic rout);
    @(negedge clk);
    cfg_poly = poly; cfg_init = init; cfg_xor = xr; cfg_width = w;
    cfg_reflect_in = rin; cfg_reflect_out = rout;
    init_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init_req = 1'b0;
  endtask

  // Offers a byte and returns just after the accepting edge.
  task automatic accept_byte(input logic [7:0] b);
    int t;
    @(negedge clk);
    msg_byte = b;
    msg_valid = 1'b1;
    t = 0;
    #1;
    while (!msg_ready && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 40) check("accept_timeout", 64'(msg_ready), 64'd1);
    @(posedge clk);
    #1 msg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic send_msg();
    for (int i = 0; i < 9; i++) begin
      accept_byte(8'h31 + 8'(i));
      wait_idle();
    end
  endtask

  // Requests the result and checks N consecutive bytes, then the return to idle.
  task automatic do_final(input string tag, input int n, input logic [63:0] exp);
    logic [63:0] e;
    @(negedge clk);
    final_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    final_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      e = exp >> (8 * i);
      check($sformatf("%s valid%0d", tag, i), 64'(out_valid), 64'd1);
      check($sformatf("%s byte%0d", tag, i), 64'(out_byte), 64'(e[7:0]));
      @(negedge clk);
    end
    check($sformatf("%s valid_end", tag), 64'(out_valid), 64'd0);
    check($sformatf("%s byte_end", tag), 64'(out_byte), 64'd0);
    check($sformatf("%s busy_end", tag), 64'(busy), 64'd0);
  endtask

  initial begin
    int highs;

    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_byte", 64'(out_byte), 64'd0);
    check("rst msg_ready", 64'(msg_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Reset configuration is width 32 with zero init/xor: four zero bytes.
    do_final("reset_cfg", 4, 64'h0);

    // CRC-8
    do_init(64'h07, 64'h0, 64'h0, 6'd8, 1'b0, 1'b0);
    send_msg();
    do_final("crc8", 1, 64'hF4);

    // CRC-32
    do_init(64'h04C11DB7, 64'hFFFFFFFF, 64'hFFFFFFFF, 6'd32, 1'b1, 1'b1);
    send_msg();
    do_final("crc32", 4, 64'hCBF43926);

    // CRC-16/ARC, repeated final_req re-emits the same result
    do_init(64'h8005, 64'h0, 64'h0, 6'd16, 1'b1, 1'b1);
    send_msg();
    do_final("arc", 2, 64'hBB3D);
    do_final("arc_again", 2, 64'hBB3D);

    // Continuous msg_valid: one accept per 9 cycles (three bytes of 0x31)
    do_init(64'h07, 64'h0, 64'h0, 6'd8, 1'b0, 1'b0);
    msg_byte = 8'h31;
    msg_valid = 1'b1;
    highs = 0;
    for (int i = 0; i < 27; i++) begin
      #1;
      check($sformatf("hs ready%0d", i), 64'(msg_ready), 64'((i % 9) == 0));
      if (msg_ready) highs++;
      @(negedge clk);
    end
    msg_valid = 1'b0;
    check("hs accepts", 64'(highs), 64'd3);
    wait_idle();
    do_final("crc8_111", 1, 64'hF1);

    // msg_valid with init_req: byte refused, accumulator holds init
    @(negedge clk);
    cfg_poly = 64'h07; cfg_init = 64'h5A; cfg_xor = 64'h0; cfg_width = 6'd8;
    cfg_reflect_in = 1'b0; cfg_reflect_out = 1'b0;
    init_req = 1'b1;
    msg_valid = 1'b1;
    msg_byte = 8'h31;
    #1;
    check("init_vs_msg ready", 64'(msg_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    init_req = 1'b0;
    msg_valid = 1'b0;
    check("init_vs_msg busy", 64'(busy), 64'd0);
    do_final("init_only", 1, 64'h5A);

    // CRC-64/XZ with width code 0
    do_init(64'h42F0E1EBA9EA3693, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 6'd0, 1'b1, 1'b1);
    send_msg();
    do_final("crc64xz", 8, 64'h995DC9BBDF1939FA);

    // Reset during the 4th SHIFT cycle, then a clean replay
    do_init(64'h04C11DB7, 64'hFFFFFFFF, 64'hFFFFFFFF, 6'd32, 1'b1, 1'b1);
    accept_byte(8'h31);
    wait_idle();
    accept_byte(8'h32);
    wait_idle();
    accept_byte(8'h33);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort msg_ready", 64'(msg_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    do_init(64'h04C11DB7, 64'hFFFFFFFF, 64'hFFFFFFFF, 6'd32, 1'b1, 1'b1);
    send_msg();
    do_final("crc32_replay", 4, 64'hCBF43926);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/granth_crc_engine.md
Name: granth_crc_engine

Overview:
Bit-serial CRC datapath downstream of the CRC Decelerator command/setup FSM. It consumes the configuration that FSM collects (poly, init, xor, width, reflect flags) and message bytes assembled from nibble pairs. It processes one message bit per clock, which is deliberately slow. On request it streams the finalised CRC out one byte per cycle, least-significant byte first.

Parameters:
BITWIDTH, 64, maximum CRC width and width of the poly/init/xor buses
CNTW, 3, width of the bit counter (8 bits per message byte)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
cfg_poly  input  BITWIDTH  generator polynomial, implicit top bit omitted, right-aligned
cfg_init  input  BITWIDTH  initial accumulator value, right-aligned
cfg_xor  input  BITWIDTH  final XOR value, right-aligned
cfg_width  input  6  CRC width; 1..63 literal, 0 encodes 64
cfg_reflect_in  input  1  process each message byte LSB first
cfg_reflect_out  input  1  bit-reverse the accumulator over width before the final XOR
init_req  input  1  latch cfg_* and load the accumulator with init
msg_valid  input  1  msg_byte is offered
msg_byte  input  8  message byte
msg_ready  output  1  engine accepts a byte this cycle
final_req  input  1  start the result stream
out_valid  output  1  out_byte is valid
out_byte  output  8  result byte, LSB byte first
busy  output  1  engine is not in IDLE

Behaviour:
- Asynchronous reset; all outputs, state and latched registers take their reset values immediately:
  - state IDLE, accumulator 0
  - latched poly, init and xor 0; latched width 32; latched reflect flags 0
  - out_valid 0, out_byte 0, busy 0
  - msg_ready is combinational: 1 after reset.
- States and transitions:
  - IDLE: all requests are accepted only here.
  - SHIFT: 8 cycles, one message bit per cycle.
  - OUTPUT: N cycles, where N = ceil(W/8) and W = 64 when the latched width is 0.
- msg_ready = (state==IDLE) & ~init_req & ~final_req.
- Priority in IDLE: init_req > final_req > msg_valid.
  - Simultaneous msg_valid with init_req or final_req is not accepted; the upstream block must hold the byte.
  - init_req together with final_req: init_req wins and final_req is ignored.
- init_req in IDLE:
  - Latches all cfg_* inputs into local registers.
  - acc <= cfg_init & mask(W).
  - Stays in IDLE.
  - The cfg_* inputs are don't-care at all other times.
  - init_req outside IDLE is ignored.
- Byte accept (msg_valid & msg_ready at a rising edge):
  - Load the shift register with msg_byte, bit-reversed when reflect_in is set; clear the bit counter; go to SHIFT.
- SHIFT, each cycle, with b = the MSB of the shift register:
  - fb = acc[W-1] ^ b.
  - acc <= ((acc << 1) ^ (fb ? poly : 0)) & mask(W).
  - Shift register shifts left by 1.
  - After the 8th bit, return to IDLE.
  - Throughput: msg_ready is low for the 8 SHIFT cycles, so the sustained rate is at most one byte per 9 cycles.
- final_req in IDLE:
  - res <= ((reflect_out ? rev_W(acc) : acc) ^ xor) & mask(W), where rev_W reverses bits [W-1:0].
  - Go to OUTPUT, byte index 0.
- OUTPUT:
  - out_valid = 1 for exactly N consecutive cycles, starting the cycle after the accept.
  - out_byte = res[8i+7:8i] for i = 0..N-1; bits above W read 0.
  - Then return to IDLE with out_valid 0 and out_byte 0.
  - The accumulator is unchanged, so a repeated final_req re-emits the same result; further bytes continue the CRC.
  - final_req and msg_valid are ignored during OUTPUT.
- busy = (state != IDLE).
- Width rules: mask(W) = all ones for W = 64. Any poly/init/xor bits above W are discarded at use via the mask.
- Reset mid-SHIFT or mid-OUTPUT: asynchronous abort, no partial output, returns to IDLE on deassertion.

Test Plan:
1. CRC-8 (width 8, poly 0x07, init 0, xor 0, no reflect), feed "123456789" (0x31..0x39), final_req -> out_valid for 1 cycle, out_byte = 0xF4.
2. CRC-32 (width 32, poly 0x04C11DB7, init 0xFFFFFFFF, xor 0xFFFFFFFF, both reflects), same message -> out_valid for 4 cycles with bytes 0x26, 0x39, 0xF4, 0xCB.
3. CRC-16/ARC (width 16, poly 0x8005, init 0, xor 0, both reflects), same message -> bytes 0x3D, 0xBB; a second final_req with no new data -> 0x3D, 0xBB again.
4. Handshake: msg_valid held high continuously -> msg_ready high 1 cycle, low 8 cycles; exactly one byte accepted per 9 cycles. msg_valid asserted with init_req in the same cycle -> byte not accepted, accumulator equals init.
5. CRC-64/XZ (cfg_width 0, poly 0x42F0E1EBA9EA3693, init and xor all ones, both reflects), "123456789" -> 8 bytes, LSB first, value 0x995DC9BBDF1939FA.
6. Assert rst during the 4th SHIFT cycle of a CRC-32 run -> immediate busy 0, out_valid 0, msg_ready 1. After re-init and replay of the full message, the result still equals 0xCBF43926.
